// File: rtl/score_pkg.sv
// Shared constants, winner codes and glyph artwork for the score overlay.
// glyph_bits() turns a seven-segment digit shape into an 11x16 bitmap.
package score_pkg;

  localparam int GLYPH_W  = 11;
  localparam int GLYPH_H  = 16;
  localparam int GLYPH_N  = GLYPH_W * GLYPH_H;
  localparam int GLYPH_AW = 8;
  localparam int RGB_W    = 3;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam logic [RGB_W-1:0] INK = 3'b111;

  // bit order g f e d c b a
  function automatic logic [6:0] seg_map(int d);
    case (d)
      0: return 7'h3f;
      1: return 7'h06;
      2: return 7'h5b;
      3: return 7'h4f;
      4: return 7'h66;
      5: return 7'h6d;
      6: return 7'h7d;
      7: return 7'h07;
      8: return 7'h7f;
      9: return 7'h6f;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [GLYPH_N-1:0] glyph_bits(int d);
    logic [GLYPH_N-1:0] g;
    logic [6:0] s;
    int r;
    int c;
    g = '0;
    s = seg_map(d);
    for (int a = 0; a < GLYPH_N; a++) begin
      r = a / GLYPH_W;
      c = a % GLYPH_W;
      g[a] = (s[0] && r <= 1 && c >= 2 && c <= 8)
          || (s[1] && r >= 1 && r <= 7 && c >= 9)
          || (s[2] && r >= 8 && r <= 14 && c >= 9)
          || (s[3] && r >= 14 && c >= 2 && c <= 8)
          || (s[4] && r >= 8 && r <= 14 && c <= 1)
          || (s[5] && r >= 1 && r <= 7 && c <= 1)
          || (s[6] && r >= 7 && r <= 8 && c >= 2 && c <= 8);
    end
    return g;
  endfunction

endpackage

// File: rtl/digit_glyph_rom.sv
// Combinational glyph lookup: digit/row/col -> rgb, 000 when out of range.
// Ports: digit[3:0], row[9:0], col[9:0] in; rgb[2:0] out.
module digit_glyph_rom
  import score_pkg::*;
(
  input  logic [3:0]       digit,
  input  logic [9:0]       row,
  input  logic [9:0]       col,
  output logic [RGB_W-1:0] rgb
);

  // entries 10..15 are blank so any 4-bit index is safe
  localparam logic [GLYPH_N-1:0] GLYPHS [16] = '{
    glyph_bits(0),  glyph_bits(1),  glyph_bits(2),
    glyph_bits(3),  glyph_bits(4),  glyph_bits(5),
    glyph_bits(6),  glyph_bits(7),  glyph_bits(8),
    glyph_bits(9),  glyph_bits(10), glyph_bits(11),
    glyph_bits(12), glyph_bits(13), glyph_bits(14),
    glyph_bits(15)
  };

  logic [GLYPH_AW-1:0] addr;
  logic                hit;

  always_comb begin
    addr = col[GLYPH_AW-1:0]
         + row[GLYPH_AW-1:0] * GLYPH_AW'(GLYPH_W);
    hit  = (col < 10'(GLYPH_W))
        && (row < 10'(GLYPH_H))
        && (digit <= 4'd9);
    rgb  = '0;
    if (hit && GLYPHS[digit][addr])
      rgb = INK;
  end

endmodule

// File: rtl/score_overlay.sv
// Pong score keeper and 2-stage digit overlay on the VGA pixel stream.
// Ports: clk, rst_n, pix_row/col/valid, point_p1/p2, game_clear in;
// rgb_out, rgb_valid, game_over, winner out. Option: SCORE_BLINK_EN.
module score_overlay
  import score_pkg::*;
#(
  parameter int DIGIT_W   = GLYPH_W,
  parameter int DIGIT_H   = GLYPH_H,
  parameter int SCORE_Y   = 16,
  parameter int P1_X      = 280,
  parameter int P2_X      = 349,
  parameter int MAX_SCORE = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       pix_row,
  input  logic [9:0]       pix_col,
  input  logic             pix_valid,
  input  logic             point_p1,
  input  logic             point_p2,
  input  logic             game_clear,
  output logic [RGB_W-1:0] rgb_out,
  output logic             rgb_valid,
  output logic             game_over,
  output logic [1:0]       winner
);

  localparam logic [3:0] MAX = 4'(MAX_SCORE);
  localparam logic [9:0] Y0  = 10'(SCORE_Y);
  localparam logic [9:0] Y1  = 10'(SCORE_Y + DIGIT_H);
  localparam logic [9:0] A0  = 10'(P1_X);
  localparam logic [9:0] A1  = 10'(P1_X + DIGIT_W);
  localparam logic [9:0] B0  = 10'(P2_X);
  localparam logic [9:0] B1  = 10'(P2_X + DIGIT_W);

  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [3:0] disp_p1;
  logic [3:0] disp_p2;
  logic       frame_start;
  logic       in_rows;
  logic       hit_p1;
  logic       hit_p2;
  logic       p1_max;
  logic       p2_max;
  logic [9:0] lcol;

  logic       s1_valid;
  logic       s1_in;
  logic [9:0] s1_row;
  logic [9:0] s1_col;
  logic [3:0] s1_digit;
  logic       s1_blank;
  logic [RGB_W-1:0] glyph_rgb;

  always_comb begin
    frame_start = pix_valid && pix_row == '0 && pix_col == '0;
    in_rows = pix_row >= Y0 && pix_row < Y1;
    hit_p1  = pix_valid && in_rows
           && pix_col >= A0 && pix_col < A1;
    hit_p2  = pix_valid && in_rows
           && pix_col >= B0 && pix_col < B1;
    lcol    = pix_col - (hit_p1 ? A0 : B0);
    p1_max  = score_p1 == MAX;
    p2_max  = score_p2 == MAX;
  end

  // winner latches from the scores present at the edge, so it
  // lands one cycle after the deciding point
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_p1  <= '0;
      score_p2  <= '0;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
    end else if (game_clear) begin
      score_p1  <= '0;
      score_p2  <= '0;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
    end else if (!game_over) begin
      if (point_p1 && score_p1 < MAX)
        score_p1 <= score_p1 + 4'd1;
      if (point_p2 && score_p2 < MAX)
        score_p2 <= score_p2 + 4'd1;
      if (p1_max || p2_max) begin
        game_over <= 1'b1;
        winner    <= {p2_max, p1_max};
      end
    end
  end

  // snapshots only move at frame start to avoid tearing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_p1 <= '0;
      disp_p2 <= '0;
    end else if (frame_start) begin
      disp_p1 <= score_p1;
      disp_p2 <= score_p2;
    end
  end

`ifdef SCORE_BLINK_EN
  logic [5:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_cnt <= '0;
    else if (frame_start)
      frame_cnt <= frame_cnt + 6'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      s1_blank <= 1'b0;
    else
      s1_blank <= game_over && frame_cnt[5]
               && (hit_p1 ? winner[0] : winner[1]);
  end
`else
  assign s1_blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_in    <= 1'b0;
      s1_row   <= '0;
      s1_col   <= '0;
      s1_digit <= '0;
    end else begin
      s1_valid <= pix_valid;
      s1_in    <= hit_p1 || hit_p2;
      s1_row   <= pix_row - Y0;
      s1_col   <= lcol;
      s1_digit <= hit_p1 ? disp_p1 : disp_p2;
    end
  end

  digit_glyph_rom u_rom (
    .digit (s1_digit),
    .row   (s1_row),
    .col   (s1_col),
    .rgb   (glyph_rgb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out   <= '0;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= s1_valid;
      rgb_out   <= (s1_in && !s1_blank) ? glyph_rgb : '0;
    end
  end

endmodule

// File: doc/score_overlay.md
Name: score_overlay

Overview:
- Holds both players' Pong scores and renders them as 11x16 3-bit digit glyphs over the VGA pixel stream.
- The pixel driver presents screen coordinates. This block converts them to glyph-local row/col, looks up the glyph, and returns a registered 3-bit pixel.
- Sits between the game FSM (point pulses) and the VGA colour mux. It is the consumer/driver side of the per-digit row/col -> rgb glyph interface.

Parameters:
- DIGIT_W, 11, glyph width in pixels.
- DIGIT_H, 16, glyph height in pixels.
- SCORE_Y, 16, screen row of the top edge of both digits.
- P1_X, 280, screen column of the left edge of player-1 digit.
- P2_X, 349, screen column of the left edge of player-2 digit.
- MAX_SCORE, 9, winning score; must be ≤9.

Ports:
- clk, in, 1, pixel clock.
- rst_n, in, 1, asynchronous active-low reset.
- pix_row, in, 10, current screen row.
- pix_col, in, 10, current screen column.
- pix_valid, in, 1, coordinates are in the visible area.
- point_p1, in, 1, one-cycle pulse: player 1 scored.
- point_p2, in, 1, one-cycle pulse: player 2 scored.
- game_clear, in, 1, synchronous clear of scores and winner.
- rgb_out, out, 3, overlay pixel; 000 means transparent.
- rgb_valid, out, 1, pix_valid delayed to align with rgb_out.
- game_over, out, 1, a player has reached MAX_SCORE.
- winner, out, 2, 00 none, 01 P1, 10 P2, 11 draw.

Behaviour:
- Reset (async, rst_n=0): scores, display snapshots, pipeline regs, rgb_out=000, rgb_valid=0, game_over=0, winner=00, frame counter=0.
- Score counters: 4-bit each, incremented on their point pulse when game_over=0.
  - Both pulses in the same cycle: both increment.
  - Pulses while game_over=1 are ignored; counters never exceed MAX_SCORE.
- Winner:
  - Registered the cycle after a counter reaches MAX_SCORE; game_over rises in the same cycle.
  - Both counters reach MAX_SCORE in the same update: winner=11.
- game_clear: next edge sets scores=0, winner=00, game_over=0.
  - game_clear beats point pulses in the same cycle.
  - game_clear does not touch the snapshots; they refresh at the next frame start.
- Display snapshot (anti-tearing): disp_p1/disp_p2 load from the live counters only on the frame-start cycle (pix_valid=1, pix_row=0, pix_col=0). Mid-frame score changes appear from the next frame.
- Frame counter: 6-bit, increments on each frame start.
- Pipeline, 2-cycle latency (coordinates at cycle N produce rgb_out/rgb_valid at N+2):
  - S1 registers:
    - in_p1 = pix_valid & row in [SCORE_Y, SCORE_Y+DIGIT_H) & col in [P1_X, P1_X+DIGIT_W);
    - in_p2 likewise for P2_X;
    - local row = pix_row − SCORE_Y;
    - local col = pix_col − window left edge;
    - selected digit = disp_p1 or disp_p2.
  - S2 registers the glyph ROM output, or 000 when neither window is hit.
- Glyph ROM: address = col + row*DIGIT_W, width 8 bits (max 175).
  - Requests with local col ≥ DIGIT_W, local row ≥ DIGIT_H, or digit > 9 return 000.
- Windows: if they overlap, P1 takes priority. The default parameters do not overlap.
- Window edges: first column/row inclusive, last+1 exclusive.
- pix_valid=0 forces rgb_out=000 two cycles later regardless of coordinates.

Optional Feature:
- SCORE_BLINK_EN defined: while game_over=1, the winner's digit renders 000 when frame counter bit 5 = 1. A draw blinks both digits; the loser's digit stays steady.
- Undefined: digits always render; the frame counter may be optimised away.

Decomposition:
- score_pkg: DIGIT_W/DIGIT_H defaults, RGB_W=3, winner codes (WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW), glyph address width 8.
- One sub-module, digit_glyph_rom:
  - Combinational digit[3:0], row[9:0], col[9:0] -> rgb[2:0].
  - Holds ten 176-entry glyph tables loaded at init.
  - Returns 000 for out-of-range requests.

Test Plan:
- Reset, then scan the full 640x480 frame with scores 0 -> rgb_out nonzero only inside the P1/P2 windows and equal to the digit-0 glyph at matching local row/col, 2 cycles after input.
- Three point_p1 pulses mid-frame -> live score 3; digit on screen stays 0 until the next frame start, then shows 3.
- Pulse P1 to 9 -> game_over=1 and winner=01 the cycle after the 9th pulse; further point_p1/point_p2 leave scores at 9/x.
- Both at 8, point_p1 and point_p2 in the same cycle -> both 9, winner=11; then game_clear with point_p1 in the same cycle -> scores 0/0, winner=00.
- Window boundaries: pix_col=P1_X+10 shows glyph col 10; P1_X+11 gives 000; pix_row=SCORE_Y+16 gives 000; pix_valid=0 inside the window gives 000 and rgb_valid=0.
- rst_n asserted mid-frame (async, between edges) -> all outputs 000/0 immediately. With SCORE_BLINK_EN and winner P2: P2 digit blank for 32 of every 64 frames, P1 digit steady.
